// File: rtl/mux_pkg.sv
// Shared constants for the registered channel multiplexer: mode encodings,
// per-channel transfer counter width and the pointer wrap helper.
package mux_pkg;

   localparam logic MODO_MANUAL = 1'b0;
   localparam logic MODO_RR     = 1'b1;

   localparam int CONTEO_W = 16;
   localparam logic [CONTEO_W-1:0] CONTEO_MAX = '1;

   // Wraps at the real channel count so non-power-of-two configurations never
   // land on a channel that does not exist.
   function automatic int siguiente_canal(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_canales_rr_arbitro.sv
// Combinational round-robin picker: first requesting channel at or after ptr,
// wrapping at N_CANALES. Produces one-hot grant, binary index and any-grant flag.
module arbitro_rr
   import mux_pkg::*;
#(
   parameter  int N_CANALES = 4,
   localparam int SEL_W     = $clog2(N_CANALES)
)(
   input  logic [N_CANALES-1:0] solicitudes,
   input  logic [SEL_W-1:0]     ptr,
   output logic [N_CANALES-1:0] grant_oh,
   output logic [SEL_W-1:0]     grant_idx,
   output logic                 hay_grant
);

   int             pos;
   logic [SEL_W-1:0] idx;

   // Scan offsets from ptr; the first hit wins and later hits are ignored.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      hay_grant = 1'b0;
      pos       = 0;
      idx       = '0;
      for (int off = 0; off < N_CANALES; off++) begin
         pos = (int'(ptr) + off) % N_CANALES;
         idx = SEL_W'(pos);
         if (!hay_grant && solicitudes[idx]) begin
            grant_oh[idx] = 1'b1;
            grant_idx     = idx;
            hay_grant     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_canales_rr.sv
// Registered N-channel multiplexer with valid/ready handshakes and manual or
// round-robin selection. Optional per-channel transfer counters: MUX_CONTEO_EN.
module mux_canales_rr
   import mux_pkg::*;
#(
   parameter  int N_CANALES = 4,
   parameter  int ANCHO     = 4,
   localparam int SEL_W     = $clog2(N_CANALES)
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_modo,
   input  logic [SEL_W-1:0]           i_sel,
   input  logic [N_CANALES*ANCHO-1:0] i_datos,
   input  logic [N_CANALES-1:0]       i_valido,
   output logic [N_CANALES-1:0]       o_listo,
   output logic [ANCHO-1:0]           o_datos,
   output logic                       o_valido,
   output logic [SEL_W-1:0]           o_canal,
   input  logic                       i_listo
`ifdef MUX_CONTEO_EN
   ,
   output logic [N_CANALES*CONTEO_W-1:0] o_conteo
`endif
);

   logic [SEL_W-1:0]     ptr;
   logic                 carga;
   logic                 transferencia;

   logic [N_CANALES-1:0] rr_oh;
   logic [SEL_W-1:0]     rr_idx;
   logic                 rr_hay;

   logic [N_CANALES-1:0] man_oh;
   logic                 man_hay;

   logic [N_CANALES-1:0] g_oh;
   logic [SEL_W-1:0]     g_idx;
   logic                 hay_grant;
   logic [ANCHO-1:0]     datos_g;
   logic [SEL_W-1:0]     ptr_sig;

   arbitro_rr #(
      .N_CANALES (N_CANALES)
   ) u_arbitro (
      .solicitudes (i_valido),
      .ptr         (ptr),
      .grant_oh    (rr_oh),
      .grant_idx   (rr_idx),
      .hay_grant   (rr_hay)
   );

   // Manual pick compares against every real channel, so an out-of-range
   // selector simply matches nothing.
   always_comb begin
      man_oh  = '0;
      man_hay = 1'b0;
      for (int k = 0; k < N_CANALES; k++) begin
         if (i_sel == SEL_W'(k) && i_valido[k]) begin
            man_oh[k] = 1'b1;
            man_hay   = 1'b1;
         end
      end
   end

   always_comb begin
      if (i_modo == MODO_RR) begin
         g_oh      = rr_oh;
         g_idx     = rr_idx;
         hay_grant = rr_hay;
      end else begin
         g_oh      = man_oh;
         g_idx     = i_sel;
         hay_grant = man_hay;
      end
   end

   // The output register accepts a word when empty or draining this cycle.
   assign carga         = !o_valido || i_listo;
   assign o_listo       = (i_rst_n && carga) ? g_oh : '0;
   assign transferencia = i_rst_n && carga && hay_grant;
   assign ptr_sig       = SEL_W'(siguiente_canal(int'(g_idx), N_CANALES));

   always_comb begin
      datos_g = '0;
      for (int k = 0; k < N_CANALES; k++) begin
         if (g_idx == SEL_W'(k)) begin
            datos_g = i_datos[k*ANCHO +: ANCHO];
         end
      end
   end

   // A load on the same edge as a drain replaces the word and keeps o_valido high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valido <= 1'b0;
         o_datos  <= '0;
         o_canal  <= '0;
         ptr      <= '0;
      end else if (transferencia) begin
         o_valido <= 1'b1;
         o_datos  <= datos_g;
         o_canal  <= g_idx;
         ptr      <= ptr_sig;
      end else if (o_valido && i_listo) begin
         o_valido <= 1'b0;
      end
   end

`ifdef MUX_CONTEO_EN
   logic [CONTEO_W-1:0] conteo [N_CANALES];

   // Counters saturate instead of wrapping so a long run never looks short.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < N_CANALES; k++) begin
         if (!i_rst_n) begin
            conteo[k] <= '0;
         end else if (transferencia && g_oh[k] && conteo[k] != CONTEO_MAX) begin
            conteo[k] <= conteo[k] + 1'b1;
         end
      end
   end

   always_comb begin
      o_conteo = '0;
      for (int k = 0; k < N_CANALES; k++) begin
         o_conteo[k*CONTEO_W +: CONTEO_W] = conteo[k];
      end
   end
`endif

endmodule

// File: tb/tb_mux_canales_rr.sv
// Self-checking bench for mux_canales_rr: a negedge monitor models grants and
// queues expected words, popping them when the output register drains.
module tb_mux_canales_rr;
   import mux_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_modo;
   logic [1:0]    i_sel;
   logic [N*W-1:0] i_datos;
   logic [N-1:0]  i_valido;
   logic [N-1:0]  o_listo;
   logic [W-1:0]  o_datos;
   logic          o_valido;
   logic [1:0]    o_canal;
   logic          i_listo;
`ifdef MUX_CONTEO_EN
   logic [N*CONTEO_W-1:0] o_conteo;
`endif

   int num_checks   = 0;
   int num_failures = 0;

   logic [5:0] sb_q[$];
   logic       m_valid      = 1'b0;
   int         m_ptr        = 0;
   logic       prev_reset   = 1'b0;

   mux_canales_rr #(
      .N_CANALES (N),
      .ANCHO     (W)
   ) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_modo   (i_modo),
      .i_sel    (i_sel),
      .i_datos  (i_datos),
      .i_valido (i_valido),
      .o_listo  (o_listo),
      .o_datos  (o_datos),
      .o_valido (o_valido),
      .o_canal  (o_canal),
      .i_listo  (i_listo)
`ifdef MUX_CONTEO_EN
      ,
      .o_conteo (o_conteo)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic modo, input logic [1:0] sel,
                                 input logic [3:0] valido, input logic listo,
                                 input logic [15:0] datos);
      @(posedge i_clk);
      #1;
      i_modo   = modo;
      i_sel    = sel;
      i_valido = valido;
      i_listo  = listo;
      i_datos  = datos;
   endtask

   // Behavioral reference: grant, ready and expected output word each cycle.
   always @(negedge i_clk) begin : monitor
      logic       hay;
      int         g;
      int         k;
      logic       carga;
      logic [3:0] exp_listo;
      logic [5:0] item;
      if (prev_reset) begin
         check_output("rst_datos", 32'(o_datos), 32'h0);
         check_output("rst_canal", 32'(o_canal), 32'h0);
      end
      check_output("o_valido", 32'(o_valido), 32'(m_valid));
      if (!i_rst_n) begin
         check_output("rst_listo", 32'(o_listo), 32'h0);
         m_valid    = 1'b0;
         m_ptr      = 0;
         prev_reset = 1'b1;
         sb_q.delete();
      end else begin
         prev_reset = 1'b0;
         hay = 1'b0;
         g   = 0;
         if (i_modo == MODO_MANUAL) begin
            if (i_valido[i_sel]) begin
               hay = 1'b1;
               g   = int'(i_sel);
            end
         end else begin
            for (int off = 0; off < N; off++) begin
               k = (m_ptr + off) % N;
               if (!hay && i_valido[k]) begin
                  hay = 1'b1;
                  g   = k;
               end
            end
         end
         carga     = !m_valid || i_listo;
         exp_listo = '0;
         if (hay && carga) exp_listo[g] = 1'b1;
         check_output("o_listo", 32'(o_listo), 32'(exp_listo));

         if (m_valid) begin
            if (sb_q.size() == 0) begin
               check_output("sb_empty", 32'(o_valido), 32'h0);
            end else if (i_listo) begin
               item = sb_q.pop_front();
               check_output("o_datos", 32'(o_datos), 32'(item[3:0]));
               check_output("o_canal", 32'(o_canal), 32'(item[5:4]));
            end else begin
               item = sb_q[0];
               check_output("stall_datos", 32'(o_datos), 32'(item[3:0]));
               check_output("stall_canal", 32'(o_canal), 32'(item[5:4]));
            end
         end

         if (hay && carga) begin
            sb_q.push_back({2'(g), i_datos[g*W +: W]});
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
         end else if (m_valid && i_listo) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures + 1);
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      i_rst_n  = 1'b0;
      i_modo   = MODO_RR;
      i_sel    = 2'd0;
      i_valido = 4'hF;
      i_listo  = 1'b1;
      i_datos  = 16'h4321;

      // Reset held with every channel requesting.
      repeat (3) @(negedge i_clk);
      check_output("rst_o_valido", 32'(o_valido), 32'h0);
      check_output("rst_o_datos", 32'(o_datos), 32'h0);
      check_output("rst_o_canal", 32'(o_canal), 32'h0);
      check_output("rst_o_listo", 32'(o_listo), 32'h0);

      // Round-robin with all channels valid: 0,1,2,3,0 back to back.
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check_output("first_grant", 32'(o_listo), 32'h1);
      for (int c = 0; c < 5; c++) begin
         apply_stimulus(MODO_RR, 2'd0, 4'hF, 1'b1, 16'h4321);
         @(negedge i_clk);
         check_output("rr_seq_canal", 32'(o_canal), 32'(c % N));
         check_output("rr_seq_valido", 32'(o_valido), 32'h1);
      end

      // Manual select channel 2 while channels 1 and 2 request.
      apply_stimulus(MODO_MANUAL, 2'd2, 4'b0110, 1'b1, 16'h0A50);
      @(negedge i_clk);
      check_output("man_listo", 32'(o_listo), 32'b0100);
      apply_stimulus(MODO_MANUAL, 2'd2, 4'b0000, 1'b1, 16'h0A50);
      @(negedge i_clk);
      check_output("man_datos", 32'(o_datos), 32'hA);
      check_output("man_canal", 32'(o_canal), 32'h2);

      // Backpressure: load a word then stall for three cycles.
      apply_stimulus(MODO_MANUAL, 2'd1, 4'b0010, 1'b1, 16'h0070);
      for (int c = 0; c < 3; c++) begin
         apply_stimulus(MODO_RR, 2'd1, 4'hF, 1'b0, 16'h9999);
         @(negedge i_clk);
         check_output("bp_listo", 32'(o_listo), 32'h0);
         check_output("bp_datos", 32'(o_datos), 32'h7);
      end
      apply_stimulus(MODO_RR, 2'd1, 4'hF, 1'b1, 16'h9999);
      apply_stimulus(MODO_RR, 2'd1, 4'h0, 1'b1, 16'h9999);
      @(negedge i_clk);
      check_output("bp_reload_valido", 32'(o_valido), 32'h1);
      check_output("bp_reload_datos", 32'(o_datos), 32'h9);

      // Sparse round-robin: ptr set to 1 via a manual transfer on channel 0.
      apply_stimulus(MODO_MANUAL, 2'd0, 4'b0001, 1'b1, 16'h3CB1);
      apply_stimulus(MODO_RR, 2'd0, 4'b0001, 1'b1, 16'h3CB2);
      @(negedge i_clk);
      check_output("sparse_wrap", 32'(o_listo), 32'b0001);
      apply_stimulus(MODO_RR, 2'd0, 4'b1001, 1'b1, 16'h3CB2);
      @(negedge i_clk);
      check_output("sparse_skip", 32'(o_listo), 32'b1000);

      // Random traffic, the monitor model checks every cycle.
      for (int c = 0; c < 300; c++) begin
         apply_stimulus(1'($urandom), 2'($urandom), 4'($urandom),
                        ($urandom_range(0, 3) != 0), 16'($urandom));
      end

      // Reset while a word is held under backpressure discards it.
      apply_stimulus(MODO_RR, 2'd0, 4'hF, 1'b0, 16'h5555);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      @(negedge i_clk);
      check_output("midrst_listo", 32'(o_listo), 32'h0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      i_listo = 1'b1;

`ifdef MUX_CONTEO_EN
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n  = 1'b1;
      i_modo   = MODO_MANUAL;
      i_sel    = 2'd3;
      i_valido = 4'b1000;
      i_listo  = 1'b1;
      repeat (70000) @(posedge i_clk);
      #1;
      i_valido = 4'b0000;
      @(negedge i_clk);
      check_output("conteo_ch3", 32'(o_conteo[63:48]), 32'hFFFF);
      check_output("conteo_ch0", 32'(o_conteo[15:0]), 32'h0);
      check_output("conteo_ch1", 32'(o_conteo[31:16]), 32'h0);
      check_output("conteo_ch2", 32'(o_conteo[47:32]), 32'h0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check_output("conteo_clear", 32'(o_conteo[63:48]), 32'h0);
`endif

      // Drain and confirm nothing is left pending in the scoreboard.
      for (int c = 0; c < 4; c++) begin
         apply_stimulus(MODO_RR, 2'd0, 4'h0, 1'b1, 16'h0000);
      end
      @(negedge i_clk);
      check_output("drain_queue", 32'(sb_q.size()), 32'h0);
      check_output("drain_valido", 32'(o_valido), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
      $finish;
   end

endmodule

// File: doc/mux_canales_rr.md
# mux_canales_rr

Registered N-channel multiplexer with per-channel valid/ready handshakes and selectable manual or round-robin channel selection. It generalises the team's 4:1 combinational data multiplexer: any channel count and width, one output register stage, and backpressure. It sits between several data producers (sensor/peripheral front-ends) and a single downstream consumer, forwarding one word per cycle.

## Interface
- N_CANALES, 4, number of input channels (≥2)
- ANCHO, 4, data width per channel in bits
- SEL_W, $clog2(N_CANALES), width of selector and channel-tag fields (derived, not overridden)

- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_modo  in  1  0 = manual (i_sel), 1 = round-robin
- i_sel  in  SEL_W  channel picked in manual mode
- i_datos  in  N_CANALES*ANCHO  channel k at bits [k*ANCHO +: ANCHO]
- i_valido  in  N_CANALES  per-channel data valid
- o_listo  out  N_CANALES  per-channel ready; at most one bit set
- o_datos  out  ANCHO  registered output word
- o_valido  out  1  o_datos holds a word
- o_canal  out  SEL_W  source channel of o_datos
- i_listo  in  1  downstream ready

## Operation
- Output stage: one register (o_datos, o_canal, o_valido). Can load (`carga`) when o_valido=0 or (o_valido & i_listo).
- Grant g: manual mode → g = i_sel if i_sel < N_CANALES and i_valido[i_sel]; else none. Round-robin → first k with i_valido[k], searching ptr, ptr+1, …, wrapping mod N_CANALES; none if i_valido = 0.
- o_listo[g] = carga when a grant exists; all other bits 0. o_listo is combinational from i_valido, i_modo, i_sel, i_listo, and the register state.
- Input transfer on channel g: i_valido[g] & o_listo[g]. On that edge: o_datos ← channel g data, o_canal ← g, o_valido ← 1.
- Output transfer: o_valido & i_listo. If no input transfer occurs on the same edge, o_valido ← 0.
- Round-robin pointer ptr (SEL_W bits): on an input transfer in either mode, ptr ← (g+1) mod N_CANALES. Otherwise held.
- Mode or i_sel changes take effect on the next grant evaluation. A held output word is never dropped or altered.
- Non-power-of-two N_CANALES: out-of-range i_sel yields no grant, and ptr wraps at N_CANALES, not 2^SEL_W.
- Reset (i_rst_n=0 at an edge): o_valido=0, o_datos=0, o_canal=0, ptr=0. While i_rst_n=0, o_listo is forced to 0. A held word is discarded on reset.

## Timing
- Latency: input transfer at edge t → word visible on o_datos/o_valido after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle with i_listo held at 1; back-to-back transfers need no bubble.
- Stall: while o_valido=1 and i_listo=0, o_datos/o_canal hold stable and all o_listo are 0.
- Simultaneous output drain and input load on the same edge: the new word replaces the old one and o_valido stays 1.
- Producers must hold data stable while i_valido=1 until accepted. Withdrawing i_valido before acceptance is allowed; that channel simply gets no transfer.

## Configuration
- MUX_CONTEO_EN defined: adds output port o_conteo (N_CANALES*16 bits, channel k at [k*16 +: 16]).
  - Each count increments on that channel's input transfer and saturates at 16'hFFFF.
  - Counts clear on reset.
- MUX_CONTEO_EN undefined: no port, no counters. Behaviour is otherwise identical.

## Structure
- Shared package mux_pkg holds:
  - MODO_MANUAL = 1'b0 and MODO_RR = 1'b1
  - CONTEO_W = 16
- Sub-module arbitro_rr: combinational round-robin picker.
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant, binary grant index, any-grant flag.
  - Parametrised by N_CANALES.
  - Instantiated once. Manual-mode selection stays in the top level.

## Test plan
- Reset: hold i_rst_n=0 with i_valido=4'hF → o_valido=0, o_datos=0, o_canal=0, o_listo=0. First grant after release goes to channel 0 (RR mode).
- Manual mode, i_sel=2, i_valido=4'b0110, data ch1=4'h5, ch2=4'hA, i_listo=1 → o_listo=4'b0100; next cycle o_datos=4'hA, o_canal=2.
- Round-robin, i_valido=4'hF held, i_listo=1 → o_canal sequence 0,1,2,3,0 on consecutive cycles with o_valido continuously 1.
- Backpressure: word on output, i_listo=0 for 3 cycles → o_datos/o_canal unchanged, o_listo=0. Raise i_listo → drain and reload on the same edge.
- Sparse RR: ptr=1, i_valido=4'b0001 → grant 0 (wrap). Then ptr=1 and i_valido=4'b1001 → grant 3.
- MUX_CONTEO_EN: 70000 transfers on ch3 → o_conteo[63:48]=16'hFFFF, other channels 0. Reset clears all counts.
